// File: rtl/riscv_wb_arbiter_if.sv
// Write-back arbiter bus: pipe lane results, long-latency handshake,
// scoreboard set/busy and the two register-file write ports.
interface riscv_wb_arbiter_if #(
    parameter int DATA_W = 32
);
    logic              p0_valid;
    logic [4:0]        p0_rd;
    logic [DATA_W-1:0] p0_data;
    logic              p1_valid;
    logic [4:0]        p1_rd;
    logic [DATA_W-1:0] p1_data;
    logic              ll_valid;
    logic              ll_ready;
    logic [4:0]        ll_rd;
    logic [DATA_W-1:0] ll_data;
    logic              sb_set_valid;
    logic [4:0]        sb_set_rd;
    logic [31:0]       sb_busy;
    logic [4:0]        waddr0;
    logic [DATA_W-1:0] wdata0;
    logic [4:0]        waddr1;
    logic [DATA_W-1:0] wdata1;

    modport master (
        output p0_valid, p0_rd, p0_data, p1_valid, p1_rd, p1_data,
        output ll_valid, ll_rd, ll_data, sb_set_valid, sb_set_rd,
        input  ll_ready, sb_busy, waddr0, wdata0, waddr1, wdata1
    );

    modport slave (
        input  p0_valid, p0_rd, p0_data, p1_valid, p1_rd, p1_data,
        input  ll_valid, ll_rd, ll_data, sb_set_valid, sb_set_rd,
        output ll_ready, sb_busy, waddr0, wdata0, waddr1, wdata1
    );
endinterface

// File: rtl/riscv_wb_arbiter.sv
// Merges two in-order lane results and buffered long-latency results onto
// the two register-file write ports, tracking outstanding LL destinations.
module riscv_wb_arbiter #(
    parameter int DEPTH = 2
) (
    input logic            clk,
    input logic            srst_n,
    riscv_wb_arbiter_if.slave wb
);
    localparam int DATA_W = 32;
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int OCC_W  = $clog2(DEPTH) + 1;

    logic [4:0]        fifo_rd   [DEPTH];
    logic [DATA_W-1:0] fifo_data [DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr, idx;
    logic [OCC_W-1:0]  occ, n_drain;
    logic              accept, ready, blocked;
    logic              live0, live1, merge;
    logic [1:0]        used;
    logic [4:0]        pa0, pa1;
    logic [DATA_W-1:0] pd0, pd1;
    logic [31:0]       clr_mask, set_mask, sb_next;

    logic [4:0]        waddr0_p1, waddr1_p1;
    logic [DATA_W-1:0] wdata0_p1, wdata1_p1;
    logic [31:0]       sb_busy_p1;

    assign live0  = wb.p0_valid && (wb.p0_rd != 5'd0);
    assign live1  = wb.p1_valid && (wb.p1_rd != 5'd0);
    assign merge  = live0 && live1 && (wb.p0_rd == wb.p1_rd);
    assign ready  = srst_n && (occ != OCC_W'(DEPTH));
    assign accept = wb.ll_valid && ready;

    // Lane writes are packed from port0 upward so a pipe write always sits
    // on the higher-priority port ahead of any LL write to the same rd.
    always_comb begin
        pa0      = '0;
        pd0      = '0;
        pa1      = '0;
        pd1      = '0;
        used     = 2'd0;
        n_drain  = '0;
        clr_mask = '0;
        blocked  = 1'b0;
        idx      = rd_ptr;
        if (merge) begin
            pa0  = wb.p1_rd;
            pd0  = wb.p1_data;
            used = 2'd1;
        end else begin
            if (live0) begin
                pa0  = wb.p0_rd;
                pd0  = wb.p0_data;
                used = 2'd1;
            end
            if (live1) begin
                if (used == 2'd0) begin
                    pa0 = wb.p1_rd;
                    pd0 = wb.p1_data;
                end else begin
                    pa1 = wb.p1_rd;
                    pd1 = wb.p1_data;
                end
                used = used + 2'd1;
            end
        end
        // rd=0 entries retire without a port; stop at the first real write
        // that finds no free port so order is preserved.
        for (int i = 0; i < DEPTH; i++) begin
            idx = rd_ptr + PTR_W'(i);
            if (!blocked && (OCC_W'(i) < occ)) begin
                if (fifo_rd[idx] == 5'd0) begin
                    n_drain = n_drain + OCC_W'(1);
                end else if (used == 2'd0) begin
                    pa0                    = fifo_rd[idx];
                    pd0                    = fifo_data[idx];
                    used                   = 2'd1;
                    n_drain                = n_drain + OCC_W'(1);
                    clr_mask[fifo_rd[idx]] = 1'b1;
                end else if (used == 2'd1) begin
                    pa1                    = fifo_rd[idx];
                    pd1                    = fifo_data[idx];
                    used                   = 2'd2;
                    n_drain                = n_drain + OCC_W'(1);
                    clr_mask[fifo_rd[idx]] = 1'b1;
                end else begin
                    blocked = 1'b1;
                end
            end
        end
    end

    assign set_mask = wb.sb_set_valid ? (32'h1 << wb.sb_set_rd) : 32'h0;
    assign sb_next  = ((sb_busy_p1 & ~clr_mask) | set_mask) & ~32'h1;

    always_ff @(posedge clk) begin
        if (accept) begin
            fifo_rd[wr_ptr]   <= wb.ll_rd;
            fifo_data[wr_ptr] <= wb.ll_data;
        end
    end

    // ---- stage p1: registered port outputs, scoreboard, FIFO control ----
    always_ff @(posedge clk) begin
        if (!srst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            occ        <= '0;
            sb_busy_p1 <= '0;
            waddr0_p1  <= '0;
            wdata0_p1  <= '0;
            waddr1_p1  <= '0;
            wdata1_p1  <= '0;
        end else begin
            wr_ptr     <= wr_ptr + PTR_W'(accept);
            rd_ptr     <= rd_ptr + PTR_W'(n_drain);
            occ        <= occ + OCC_W'(accept) - n_drain;
            sb_busy_p1 <= sb_next;
            waddr0_p1  <= pa0;
            wdata0_p1  <= pd0;
            waddr1_p1  <= pa1;
            wdata1_p1  <= pd1;
        end
    end

    assign wb.ll_ready = ready;
    assign wb.sb_busy  = sb_busy_p1;
    assign wb.waddr0   = waddr0_p1;
    assign wb.wdata0   = wdata0_p1;
    assign wb.waddr1   = waddr1_p1;
    assign wb.wdata1   = wdata1_p1;
endmodule

// File: tb/tb_riscv_wb_arbiter.sv
// Bench for riscv_wb_arbiter: table vectors, directed corner sequences and
// random traffic against a queue-based reference model.
module tb_riscv_wb_arbiter;
    localparam int DEPTH = 2;

    logic clk = 1'b0;
    logic srst_n = 1'b0;
    int   ncmp = 0;
    int   nerr = 0;

    riscv_wb_arbiter_if bus ();

    riscv_wb_arbiter #(.DEPTH(DEPTH)) dut (
        .clk    (clk),
        .srst_n (srst_n),
        .wb     (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    typedef struct {
        logic        v0;
        logic [4:0]  rd0;
        logic [31:0] d0;
        logic        v1;
        logic [4:0]  rd1;
        logic [31:0] d1;
        logic [4:0]  wa0;
        logic [31:0] wd0;
        logic [4:0]  wa1;
        logic [31:0] wd1;
    } vec_t;

    ent_t        q[$];
    logic [31:0] m_sb = '0;
    logic [4:0]  e_wa0 = '0, e_wa1 = '0;
    logic [31:0] e_wd0 = '0, e_wd1 = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference: lane writes listed in program order, then FIFO head entries
    // fill whatever ports are left; new entries join after the drain.
    task automatic model_step();
        ent_t ports[$];
        ent_t e;
        bit   rdy;
        bit   l0, l1;
        if (!srst_n) begin
            q.delete();
            m_sb  = '0;
            e_wa0 = '0; e_wd0 = '0; e_wa1 = '0; e_wd1 = '0;
            return;
        end
        rdy = (q.size() != DEPTH);
        l0  = bus.p0_valid && bus.p0_rd != 0;
        l1  = bus.p1_valid && bus.p1_rd != 0;
        if (l0 && l1 && bus.p0_rd == bus.p1_rd) begin
            e.rd = bus.p1_rd; e.data = bus.p1_data; ports.push_back(e);
        end else begin
            if (l0) begin e.rd = bus.p0_rd; e.data = bus.p0_data; ports.push_back(e); end
            if (l1) begin e.rd = bus.p1_rd; e.data = bus.p1_data; ports.push_back(e); end
        end
        while (q.size() > 0) begin
            if (q[0].rd == 0) begin
                void'(q.pop_front());
            end else if (ports.size() < 2) begin
                ports.push_back(q[0]);
                m_sb[q[0].rd] = 1'b0;
                void'(q.pop_front());
            end else begin
                break;
            end
        end
        if (bus.sb_set_valid && bus.sb_set_rd != 0) m_sb[bus.sb_set_rd] = 1'b1;
        if (bus.ll_valid && rdy) begin
            e.rd = bus.ll_rd; e.data = bus.ll_data; q.push_back(e);
        end
        e_wa0 = ports.size() > 0 ? ports[0].rd   : 5'd0;
        e_wd0 = ports.size() > 0 ? ports[0].data : 32'd0;
        e_wa1 = ports.size() > 1 ? ports[1].rd   : 5'd0;
        e_wd1 = ports.size() > 1 ? ports[1].data : 32'd0;
    endtask

    task automatic step();
        @(negedge clk);
        chk("ll_ready", {31'd0, bus.ll_ready}, {31'd0, srst_n && (q.size() != DEPTH)});
        model_step();
        @(posedge clk);
        #1;
        chk("waddr0", {27'd0, bus.waddr0}, {27'd0, e_wa0});
        chk("wdata0", bus.wdata0, e_wd0);
        chk("waddr1", {27'd0, bus.waddr1}, {27'd0, e_wa1});
        chk("wdata1", bus.wdata1, e_wd1);
        chk("sb_busy", bus.sb_busy, m_sb);
    endtask

    task automatic set_lanes(input logic v0, input logic [4:0] r0, input logic [31:0] d0,
                             input logic v1, input logic [4:0] r1, input logic [31:0] d1);
        bus.p0_valid = v0; bus.p0_rd = r0; bus.p0_data = d0;
        bus.p1_valid = v1; bus.p1_rd = r1; bus.p1_data = d1;
    endtask

    task automatic set_ll(input logic v, input logic [4:0] r, input logic [31:0] d);
        bus.ll_valid = v; bus.ll_rd = r; bus.ll_data = d;
    endtask

    task automatic set_sb(input logic v, input logic [4:0] r);
        bus.sb_set_valid = v; bus.sb_set_rd = r;
    endtask

    task automatic idle();
        set_lanes(0, 0, 0, 0, 0, 0);
        set_ll(0, 0, 0);
        set_sb(0, 0);
    endtask

    vec_t tbl[7];

    initial begin
        tbl[0] = '{1'b1, 5'd5,  32'h11,       1'b1, 5'd6, 32'h22,   5'd5,  32'h11,       5'd6, 32'h22};
        tbl[1] = '{1'b1, 5'd7,  32'hAAAA,     1'b1, 5'd7, 32'hBBBB, 5'd7,  32'hBBBB,     5'd0, 32'h0};
        tbl[2] = '{1'b1, 5'd0,  32'h33,       1'b1, 5'd8, 32'h44,   5'd8,  32'h44,       5'd0, 32'h0};
        tbl[3] = '{1'b0, 5'd3,  32'h55,       1'b1, 5'd9, 32'h66,   5'd9,  32'h66,       5'd0, 32'h0};
        tbl[4] = '{1'b1, 5'd4,  32'h77,       1'b0, 5'd4, 32'h88,   5'd4,  32'h77,       5'd0, 32'h0};
        tbl[5] = '{1'b1, 5'd0,  32'h1,        1'b1, 5'd0, 32'h2,    5'd0,  32'h0,        5'd0, 32'h0};
        tbl[6] = '{1'b1, 5'd31, 32'hFFFFFFFF, 1'b1, 5'd1, 32'h0,    5'd31, 32'hFFFFFFFF, 5'd1, 32'h0};

        idle();
        srst_n = 1'b0;
        step();
        step();
        chk("rst_waddr0", {27'd0, bus.waddr0}, 32'd0);
        chk("rst_sb_busy", bus.sb_busy, 32'd0);
        chk("rst_ll_ready", {31'd0, bus.ll_ready}, 32'd0);
        srst_n = 1'b1;
        step();

        for (int i = 0; i < 7; i++) begin
            set_lanes(tbl[i].v0, tbl[i].rd0, tbl[i].d0, tbl[i].v1, tbl[i].rd1, tbl[i].d1);
            step();
            chk($sformatf("vec%0d_waddr0", i), {27'd0, bus.waddr0}, {27'd0, tbl[i].wa0});
            chk($sformatf("vec%0d_wdata0", i), bus.wdata0, tbl[i].wd0);
            chk($sformatf("vec%0d_waddr1", i), {27'd0, bus.waddr1}, {27'd0, tbl[i].wa1});
            chk($sformatf("vec%0d_wdata1", i), bus.wdata1, tbl[i].wd1);
        end
        idle();
        step();

        // Backpressure with both lanes busy, then a two-entry drain.
        set_lanes(1, 1, 32'hA1, 1, 2, 32'hA2);
        set_ll(1, 11, 32'h111); step();
        set_ll(1, 12, 32'h222); step();
        chk("bp_ready_low", {31'd0, bus.ll_ready}, 32'd0);
        set_ll(1, 13, 32'h333); step();
        set_lanes(0, 0, 0, 0, 0, 0);
        step();
        chk("bp_drain_wa0", {27'd0, bus.waddr0}, 32'd11);
        chk("bp_drain_wd0", bus.wdata0, 32'h111);
        chk("bp_drain_wa1", {27'd0, bus.waddr1}, 32'd12);
        chk("bp_drain_wd1", bus.wdata1, 32'h222);
        step();
        idle();
        step();
        chk("bp_third_wa0", {27'd0, bus.waddr0}, 32'd13);

        // Scoreboard set, hold until written, and set-wins-over-clear.
        set_sb(1, 10); step();
        chk("sb_set10", {31'd0, bus.sb_busy[10]}, 32'd1);
        set_sb(0, 0); set_ll(1, 10, 32'h1234); step();
        chk("sb_hold10", {31'd0, bus.sb_busy[10]}, 32'd1);
        idle(); step();
        chk("sb_wr_wa0", {27'd0, bus.waddr0}, 32'd10);
        chk("sb_wr_wd0", bus.wdata0, 32'h1234);
        chk("sb_clr10", {31'd0, bus.sb_busy[10]}, 32'd0);
        set_ll(1, 10, 32'h5678); step();
        set_ll(0, 0, 0); set_sb(1, 10); step();
        chk("sb_setwins_wa0", {27'd0, bus.waddr0}, 32'd10);
        chk("sb_setwins", {31'd0, bus.sb_busy[10]}, 32'd1);
        set_sb(0, 0); set_ll(1, 10, 32'h9); step();
        idle(); step();

        // x0 filtering on lanes, scoreboard and LL entries.
        set_ll(1, 3, 32'h33); set_sb(1, 0); step();
        chk("x0_sb", bus.sb_busy, 32'd0);
        idle(); set_lanes(1, 0, 32'hDEAD, 0, 0, 0); step();
        chk("x0_ll_port0", {27'd0, bus.waddr0}, 32'd3);
        chk("x0_ll_data0", bus.wdata0, 32'h33);
        chk("x0_port1", {27'd0, bus.waddr1}, 32'd0);
        idle(); set_ll(1, 0, 32'h55); step();
        idle(); step();
        chk("x0_llrd0_wa0", {27'd0, bus.waddr0}, 32'd0);
        chk("x0_llrd0_wd0", bus.wdata0, 32'd0);

        // Pipe write to a busy rd: pipe on port0, LL on port1, bit clears.
        set_sb(1, 9); step();
        set_sb(0, 0); set_ll(1, 9, 32'hDEAD); step();
        idle(); set_lanes(0, 0, 0, 1, 9, 32'h99); step();
        chk("viol_wa0", {27'd0, bus.waddr0}, 32'd9);
        chk("viol_wd0", bus.wdata0, 32'h99);
        chk("viol_wa1", {27'd0, bus.waddr1}, 32'd9);
        chk("viol_wd1", bus.wdata1, 32'hDEAD);
        chk("viol_sb9", {31'd0, bus.sb_busy[9]}, 32'd0);
        idle(); step();

        // Reset with two buffered entries and a pending scoreboard bit.
        set_sb(1, 10); set_lanes(1, 1, 32'h1, 1, 2, 32'h2); step();
        set_sb(0, 0); set_ll(1, 10, 32'hA); step();
        set_ll(1, 11, 32'hB); step();
        chk("mrst_pre_sb", bus.sb_busy, 32'h400);
        chk("mrst_pre_full", {31'd0, bus.ll_ready}, 32'd0);
        idle(); srst_n = 1'b0; step();
        chk("mrst_wa0", {27'd0, bus.waddr0}, 32'd0);
        chk("mrst_wa1", {27'd0, bus.waddr1}, 32'd0);
        chk("mrst_sb", bus.sb_busy, 32'd0);
        chk("mrst_ready", {31'd0, bus.ll_ready}, 32'd0);
        srst_n = 1'b1;
        #1;
        chk("mrst_rel_ready", {31'd0, bus.ll_ready}, 32'd1);
        step();
        step();
        chk("mrst_rel_wa0", {27'd0, bus.waddr0}, 32'd0);
        chk("mrst_rel_wa1", {27'd0, bus.waddr1}, 32'd0);

        // Random traffic against the reference model.
        for (int n = 0; n < 3000; n++) begin
            srst_n = ($urandom_range(0, 199) != 0);
            set_lanes($urandom_range(0, 2) != 0, 5'($urandom_range(0, 7)), $urandom,
                      $urandom_range(0, 2) != 0, 5'($urandom_range(0, 7)), $urandom);
            if ($urandom_range(0, 5) == 0) set_lanes(0, 0, 0, 0, 0, 0);
            set_ll($urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom);
            set_sb($urandom_range(0, 3) == 0, 5'($urandom_range(0, 7)));
            step();
        end
        srst_n = 1'b1;
        idle();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
